// File: rtl/syn_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// syn_fifo_rd_stream
//
// Read-side adapter for syn_fifo. It pulls words out of the FIFO, which has a
// 1-cycle registered read latency, and presents them as a valid/ready stream.
// A 2-entry skid buffer (head/tail) absorbs the read latency so that the
// stream runs at 1 word/cycle and back-pressure is handled correctly. It also
// keeps a wrapping count of the words delivered downstream.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   srst        synchronous reset, active-high
//   fifo_empty  syn_fifo empty flag
//   fifo_data   syn_fifo data_out; valid in the cycle after fifo_ren is sampled
//   fifo_ren    read enable to syn_fifo (combinational)
//   out_valid   output word valid (registered)
//   out_data    output word (registered, equals the buffer head)
//   out_ready   downstream accept; a word transfers when valid & ready at edge
//   xfer_cnt    number of accepted words, modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module syn_fifo_rd_stream #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_ren,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     tail_q, tail_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       pop;
    logic       cap;
    logic [1:0] occ_after_pop;
    logic [2:0] level;

    assign out_valid     = (occ_q != 2'd0);
    assign out_data      = head_q;
    assign xfer_cnt      = cnt_q;

    assign pop           = out_valid & out_ready;
    assign cap           = inflight_q;
    assign occ_after_pop = occ_q - {1'b0, pop};

    // Words committed to the buffer once this edge has passed: what is held,
    // plus the word already on its way, minus the word leaving now. A new read
    // is only issued if its word is guaranteed a slot when it lands. The path
    // from out_ready is deliberate: it lets a pop free a slot in the same cycle.
    assign level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_ren = !srst && !fifo_empty && (level < 3'd2);

    always_comb begin
        occ_d      = occ_q;
        inflight_d = inflight_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;

        if (srst) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
        end else begin
            inflight_d = fifo_ren;

            // Shift first, so a landing word that follows a pop at occ == 2
            // goes into the freshly vacated tail.
            if (pop && (occ_q == 2'd2))
                head_d = tail_q;

            // At occ == 1 with a pop, the incoming word replaces the head.
            if (cap) begin
                if (occ_after_pop == 2'd0)
                    head_d = fifo_data;
                else
                    tail_d = fifo_data;
            end

            occ_d = occ_after_pop + {1'b0, cap};
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        occ_q      <= occ_d;
        inflight_q <= inflight_d;
        head_q     <= head_d;
        tail_q     <= tail_d;
        cnt_q      <= cnt_d;
    end

endmodule

// File: tb/tb_syn_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_syn_fifo_rd_stream
//
// Directed bench for syn_fifo_rd_stream. A small behavioural syn_fifo (depth
// 16, registered data_out) feeds the adapter; a monitor records every read
// issue and every accepted output word with its cycle number.
// ---------------------------------------------------------------------------
module tb_syn_fifo_rd_stream;

    localparam int WIDTH = 16;
    localparam int CNTW  = 4;

    logic             clk;
    logic             srst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_ren;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CNTW-1:0]  xfer_cnt;

    syn_fifo_rd_stream #(.WIDTH(WIDTH), .CNT_WIDTH(CNTW)) dut (
        .clk        (clk),
        .srst       (srst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_ren   (fifo_ren),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .xfer_cnt   (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural syn_fifo
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] mem [16];
    logic [3:0]       wp, rp;
    logic [4:0]       fcnt;
    logic             do_wr, do_rd;

    assign fifo_empty = (fcnt == 5'd0);
    assign do_wr      = wr_en && (fcnt != 5'd16);
    assign do_rd      = fifo_ren && (fcnt != 5'd0);

    always @(posedge clk) begin
        if (srst) begin
            wp        <= 4'd0;
            rp        <= 4'd0;
            fcnt      <= 5'd0;
            fifo_data <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= wr_data;
                wp      <= wp + 4'd1;
            end
            if (do_rd) begin
                fifo_data <= mem[rp];
                rp        <= rp + 4'd1;
            end
            fcnt <= fcnt + {4'd0, do_wr} - {4'd0, do_rd};
        end
    end

    // Scoreboard / monitor
    int               total = 0;
    int               bad   = 0;
    int               cyc   = 0;
    int               ren_cnt;
    int               vld_cnt;
    int               ren_cyc[$];
    int               pop_cyc[$];
    logic [WIDTH-1:0] rx[$];
    logic [WIDTH-1:0] sent[$];

    always @(posedge clk) begin
        if (!srst) begin
            if (fifo_ren) begin
                ren_cnt++;
                ren_cyc.push_back(cyc);
            end
            if (out_valid)
                vld_cnt++;
            if (out_valid && out_ready) begin
                rx.push_back(out_data);
                pop_cyc.push_back(cyc);
            end
            // A landing word must always find a free slot.
            total++;
            assert (!(dut.inflight_q && dut.occ_q == 2'd2 && !(out_valid && out_ready)))
            else begin
                bad++;
                $error("FAIL overflow: observed cap at occ=%0d without pop, expected none", dut.occ_q);
            end
        end
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        rx.delete();
        sent.delete();
        ren_cyc.delete();
        pop_cyc.delete();
        ren_cnt = 0;
        vld_cnt = 0;
    endtask

    task automatic do_reset();
        srst      = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        srst = 1'b0;
        clear_sb();
    endtask

    task automatic wr(input logic [WIDTH-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        step();
        wr_en   = 1'b0;
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx.size()) ? {16'd0, rx[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic int pc(input int i);
        return (i < pop_cyc.size()) ? pop_cyc[i] : -1000;
    endfunction

    function automatic int rc(input int i);
        return (i < ren_cyc.size()) ? ren_cyc[i] : -1000;
    endfunction

    initial begin
        int mism;
        int written;
        int guard;

        // ---- reset state ----
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_cnt",   xfer_cnt,  0);
        chk("rst_ren",   fifo_ren,  0);

        // ---- basic stream: 0..7 with out_ready high ----
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) wr(WIDTH'(i));
        repeat (6) step();
        chk("basic_n", rx.size(), 8);
        for (int i = 0; i < 8; i++) chk("basic_data", rx_at(i), i);
        chk("basic_lat",  pc(0) - rc(0), 2);
        chk("basic_rate", pc(7) - pc(0), 7);
        chk("basic_cnt",  xfer_cnt, 8);
        chk("basic_ren_idle", fifo_ren, 0);
        chk("basic_vld_idle", out_valid, 0);

        // ---- backpressure: 8 words queued, out_ready low ----
        do_reset();
        for (int i = 0; i < 8; i++) wr(WIDTH'(i));
        repeat (4) step();
        chk("bp_ren_cnt", ren_cnt, 2);
        chk("bp_ren_now", fifo_ren, 0);
        chk("bp_valid",   out_valid, 1);
        chk("bp_data",    out_data, 0);
        step();
        chk("bp_hold",    out_data, 0);
        out_ready = 1'b1;
        repeat (12) step();
        chk("bp_n", rx.size(), 8);
        for (int i = 0; i < 8; i++) chk("bp_data_seq", rx_at(i), i);
        chk("bp_rate", pc(7) - pc(0), 7);
        chk("bp_cnt",  xfer_cnt, 8);

        // ---- single-cycle stall mid-stream ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en     = (i < 8);
            wr_data   = WIDTH'(i);
            out_ready = (i != 5);
            step();
            if (i == 5) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold",  out_data, 2);
            end
            if (i == 6) chk("stall_next", out_data, 3);
        end
        wr_en = 1'b0;
        chk("stall_n", rx.size(), 8);
        for (int i = 0; i < 8; i++) chk("stall_seq", rx_at(i), i);
        chk("stall_span", pc(7) - pc(0), 8);
        chk("stall_cnt",  xfer_cnt, 8);

        // ---- trickle: one word every 5 cycles ----
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr(WIDTH'(16'h10 + k));
            repeat (4) step();
        end
        chk("trk_n", rx.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("trk_data", rx_at(k), 32'h10 + k);
            chk("trk_lat",  pc(k) - rc(k), 2);
        end
        chk("trk_vld_cycles", vld_cnt, 3);
        chk("trk_ren_cnt",    ren_cnt, 3);

        // ---- reset mid-stream with a word in flight ----
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) wr(WIDTH'(16'h20 + i));
        repeat (6) step();
        chk("mr_pre_cnt", xfer_cnt, 5);
        out_ready = 1'b0;
        wr(16'h0030);
        wr(16'h0031);
        // A read is in flight and the FIFO is non-empty here.
        srst = 1'b1;
        #1;
        chk("mr_ren_forced", fifo_ren, 0);
        step();
        chk("mr_valid", out_valid, 0);
        chk("mr_cnt",   xfer_cnt, 0);
        chk("mr_data",  out_data, 0);
        step();
        srst = 1'b0;
        clear_sb();
        out_ready = 1'b1;
        wr(16'hAAAA);
        repeat (5) step();
        chk("mr_post_n",    rx.size(), 1);
        chk("mr_post_data", rx_at(0), 32'hAAAA);
        chk("mr_post_cnt",  xfer_cnt, 1);

        // ---- random soak ----
        do_reset();
        written = 0;
        guard   = 0;
        while (rx.size() < 1000 && guard < 20000) begin
            wr_en = (written < 1000) && (fcnt < 5'd16) && ($urandom_range(1) == 1);
            if (wr_en) begin
                wr_data = WIDTH'($urandom);
                sent.push_back(wr_data);
                written++;
            end
            out_ready = ($urandom_range(1) == 1);
            step();
            guard++;
        end
        wr_en     = 1'b0;
        out_ready = 1'b0;
        chk("soak_done", rx.size(), 1000);
        mism = 0;
        for (int i = 0; i < 1000; i++)
            if (i >= rx.size() || i >= sent.size() || rx[i] !== sent[i]) mism++;
        chk("soak_order", mism, 0);
        chk("soak_cnt",   xfer_cnt, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
